// File: rtl/mc_pkg.sv
// Shared encodings for the handshaked multicycle controller: state codes,
// opcodes, C-type function bit positions, datapath select values and trap codes.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_LOAD_MEM  = 4'd2,
      ST_LOAD_WB   = 4'd3,
      ST_STORE_MEM = 4'd4,
      ST_JUMP      = 4'd5,
      ST_BRZ       = 4'd6,
      ST_C_EXEC    = 4'd7,
      ST_C_WB      = 4'd8,
      ST_I_EXEC    = 4'd9,
      ST_I_WB      = 4'd10,
      ST_HALT      = 4'd15
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_JUMP  = 4'b0010;
   localparam logic [3:0] OP_BRZ   = 4'b0100;
   localparam logic [3:0] OP_CTYPE = 4'b1000;
   localparam logic [3:0] OP_ADDI  = 4'b1100;
   localparam logic [3:0] OP_SUBI  = 4'b1101;
   localparam logic [3:0] OP_ANDI  = 4'b1110;
   localparam logic [3:0] OP_ORI   = 4'b1111;

   localparam int F_MOVETO   = 0;
   localparam int F_MOVEFROM = 1;
   localparam int F_ADD      = 2;
   localparam int F_SUB      = 3;
   localparam int F_AND      = 4;
   localparam int F_OR       = 5;
   localparam int F_NOT      = 6;
   localparam int F_NOP      = 7;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;
   localparam logic [1:0] ALUOP_IMM  = 2'b11;

   localparam logic [1:0] ALUA_PC  = 2'b00;
   localparam logic [1:0] ALUA_IMM = 2'b01;
   localparam logic [1:0] ALUA_ACC = 2'b10;

   localparam logic [1:0] M2R_ALU      = 2'b00;
   localparam logic [1:0] M2R_MEM      = 2'b01;
   localparam logic [1:0] M2R_MOVEFROM = 2'b10;
   localparam logic [1:0] M2R_MOVETO   = 2'b11;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_JUMP = 2'b01;
   localparam logic [1:0] PCSRC_BR   = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_LOAD_MEM) || (s == ST_STORE_MEM);
   endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Wait-state counter for memory accesses; pulses timeout on the wait cycle
// that brings the count to MEM_TIMEOUT while mem_ready is still low.
module mc_mem_wait #(
   parameter int TMO_W       = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic in_mem_state,
   input  logic state_change,
   input  logic mem_ready,
   output logic timeout
);

   logic [TMO_W-1:0] cnt;

   // A ready arriving on the boundary cycle is not a wait, so it completes.
   assign timeout = in_mem_state && !mem_ready && (cnt == TMO_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || state_change || !in_mem_state)
         cnt <= '0;
      else if (!mem_ready)
         cnt <= cnt + TMO_W'(1);
   end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle controller for the 16-bit accumulator CPU with memory handshake
// and sticky trap; MC_PERF_CNT_EN adds cycle/instruction counters.
//
// state      | meaning
// FETCH(0)   | read instruction, PC+1; waits for mem_ready
// DECODE(1)  | dispatch on opcode / func legality
// LOAD_MEM(2)| data read; waits for mem_ready
// LOAD_WB(3) | memory data into register
// STORE_MEM(4)| data write; waits for mem_ready
// JUMP(5)    | PC <- jump target
// BRZ(6)     | compare, conditional PC write
// C_EXEC(7)  | C-type ALU operation
// C_WB(8)    | C-type writeback selected by func
// I_EXEC(9)  | immediate ALU operation
// I_WB(10)   | immediate writeback
// HALT(15)   | sticky trap, left only by rst
module mc_ctrl_hs
   import mc_pkg::*;
#(
   parameter int OPC_W       = 4,
   parameter int FUNC_W      = 9,
   parameter int TMO_W       = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [FUNC_W-1:0] func,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              IorD,
   output logic              MEMread,
   output logic              MEMwrite,
   output logic              IRwrite,
   output logic              PCwrite,
   output logic              PCwritecond,
   output logic              regwrite,
   output logic              regDst,
   output logic              ALUsrcB,
   output logic [1:0]        ALUsrcA,
   output logic [1:0]        ALUop,
   output logic [1:0]        Memtoreg,
   output logic [1:0]        PCsrc,
   output logic              halted,
   output logic [1:0]        err_code,
   output logic [3:0]        psout
`ifdef MC_PERF_CNT_EN
   ,
   output logic [31:0]       cyc_cnt,
   output logic [31:0]       instr_cnt
`endif
);

   state_t     state, state_nx;
   logic       halted_q;
   logic [1:0] err_q, trap_err;
   logic       in_mem, timeout, func_ok;

   // zero is consumed by the datapath's branch gate, not by the sequencer.
   logic unused_zero;
   assign unused_zero = zero;

   assign in_mem  = is_mem_state(state);
   assign func_ok = (func != '0) && ((func & (func - FUNC_W'(1))) == '0)
                    && ((func >> (F_NOP + 1)) == '0);

   mc_mem_wait #(.TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
      .clk          (clk),
      .rst          (rst),
      .in_mem_state (in_mem),
      .state_change (state_nx != state),
      .mem_ready    (mem_ready),
      .timeout      (timeout)
   );

   always_comb begin
      state_nx = state;
      trap_err = ERR_NONE;
      case (state)
         ST_FETCH:     if (mem_ready) state_nx = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OPC_W'(OP_LOAD):  state_nx = ST_LOAD_MEM;
               OPC_W'(OP_STORE): state_nx = ST_STORE_MEM;
               OPC_W'(OP_JUMP):  state_nx = ST_JUMP;
               OPC_W'(OP_BRZ):   state_nx = ST_BRZ;
               OPC_W'(OP_CTYPE): state_nx = func_ok ? ST_C_EXEC : ST_HALT;
               OPC_W'(OP_ADDI), OPC_W'(OP_SUBI),
               OPC_W'(OP_ANDI), OPC_W'(OP_ORI): state_nx = ST_I_EXEC;
               default:          state_nx = ST_HALT;
            endcase
            if (state_nx == ST_HALT) trap_err = ERR_ILLEGAL;
         end
         ST_LOAD_MEM:  if (mem_ready) state_nx = ST_LOAD_WB;
         ST_STORE_MEM: if (mem_ready) state_nx = ST_FETCH;
         ST_C_EXEC:    state_nx = ST_C_WB;
         ST_I_EXEC:    state_nx = ST_I_WB;
         ST_HALT:      state_nx = ST_HALT;
         default:      state_nx = ST_FETCH;
      endcase
      if (timeout) begin
         state_nx = ST_HALT;
         trap_err = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FETCH;
         halted_q <= 1'b0;
         err_q    <= ERR_NONE;
      end else begin
         state <= state_nx;
         if (state_nx == ST_HALT && !halted_q) begin
            halted_q <= 1'b1;
            err_q    <= trap_err;
         end
      end
   end

   // Reset gates every output in the same cycle so an in-flight request drops at once.
   always_comb begin
      mem_req     = 1'b0;
      IorD        = 1'b0;
      MEMread     = 1'b0;
      MEMwrite    = 1'b0;
      IRwrite     = 1'b0;
      PCwrite     = 1'b0;
      PCwritecond = 1'b0;
      regwrite    = 1'b0;
      regDst      = 1'b0;
      ALUsrcB     = 1'b0;
      ALUsrcA     = ALUA_PC;
      ALUop       = ALUOP_ADD;
      Memtoreg    = M2R_ALU;
      PCsrc       = PCSRC_ALU;
      if (!rst) begin
         case (state)
            ST_FETCH: begin
               MEMread = 1'b1;
               mem_req = 1'b1;
               ALUsrcB = 1'b1;
               IRwrite = mem_ready;
               PCwrite = mem_ready;
            end
            ST_LOAD_MEM: begin
               IorD    = 1'b1;
               MEMread = 1'b1;
               mem_req = 1'b1;
            end
            ST_LOAD_WB: begin
               Memtoreg = M2R_MEM;
               regwrite = 1'b1;
            end
            ST_STORE_MEM: begin
               IorD     = 1'b1;
               MEMwrite = 1'b1;
               mem_req  = 1'b1;
            end
            ST_JUMP: begin
               PCsrc   = PCSRC_JUMP;
               PCwrite = 1'b1;
            end
            ST_BRZ: begin
               ALUsrcA     = ALUA_ACC;
               ALUop       = ALUOP_SUB;
               PCsrc       = PCSRC_BR;
               PCwritecond = 1'b1;
            end
            ST_C_EXEC: begin
               ALUsrcA = ALUA_ACC;
               ALUop   = ALUOP_FUNC;
            end
            ST_C_WB: begin
               if (func[F_MOVETO]) begin
                  Memtoreg = M2R_MOVETO;
                  regDst   = 1'b1;
                  regwrite = 1'b1;
               end else if (func[F_MOVEFROM]) begin
                  Memtoreg = M2R_MOVEFROM;
                  regwrite = 1'b1;
               end else if (!func[F_NOP]) begin
                  regwrite = 1'b1;
               end
            end
            ST_I_EXEC: begin
               ALUsrcA = ALUA_IMM;
               ALUop   = ALUOP_IMM;
            end
            ST_I_WB:   regwrite = 1'b1;
            default: ;
         endcase
      end
   end

   assign halted   = halted_q & ~rst;
   assign err_code = rst ? ERR_NONE : err_q;
   assign psout    = rst ? 4'd0 : state;

`ifdef MC_PERF_CNT_EN
   logic [31:0] cyc_q, instr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q   <= '0;
         instr_q <= '0;
      end else begin
         if (state != ST_HALT && cyc_q != '1)
            cyc_q <= cyc_q + 32'd1;
         if (state != ST_FETCH && state_nx == ST_FETCH && instr_q != '1)
            instr_q <= instr_q + 32'd1;
      end
   end

   assign cyc_cnt   = rst ? '0 : cyc_q;
   assign instr_cnt = rst ? '0 : instr_q;
`endif

endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
- Parametrised successor to the fixed-latency multicycle controller of the 16-bit accumulator CPU.
- Moore FSM that sequences fetch/decode/execute/writeback and drives every datapath select and enable.
- New over the previous generation:
  - memory ready/request handshake with a wait-state timeout;
  - illegal-opcode and timeout trap into a sticky HALT state with an error code.

Parameters:
- OPC_W, 4, opcode width (instr[15:12]).
- FUNC_W, 9, one-hot C-type function field width (instr[11:3]).
- TMO_W, 4, width of the wait-state timeout counter.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready; must be ≤ 2^TMO_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opcode  in  OPC_W  IR opcode field
- func  in  FUNC_W  IR function field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  access request, held until mem_ready
- IorD, MEMread, MEMwrite, IRwrite, PCwrite, PCwritecond, regwrite, regDst, ALUsrcB  out  1 each  datapath enables/selects
- ALUsrcA, ALUop, Memtoreg, PCsrc  out  2 each  datapath selects
- halted  out  1  sticky trap indicator
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
- psout  out  4  current state encoding

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset rst is synchronous, active-high.
  - On rst: state=FETCH, timeout counter=0, halted=0, err_code=00.
  - Every output is forced to 0 while rst=1.
- Outputs are Moore, decoded from the state register, except the mem_ready-gated enables noted below.
- Opcodes: LOAD 0000, STORE 0001, JUMP 0010, BRZ 0100, CTYPE 1000, ADDI 1100, SUBI 1101, ANDI 1110, ORI 1111. All others are illegal.
- CTYPE func one-hot bits 0..7: MOVETO, MOVEFROM, ADD, SUB, AND, OR, NOT, NOP. A func that is not one-hot is illegal.
- States and transitions:
  - FETCH(0):
    - Drives IorD=0, MEMread=1, mem_req=1, ALUsrcA=00, ALUsrcB=1, ALUop=00 (add), PCsrc=00.
    - IRwrite and PCwrite assert only in the cycle mem_ready=1; that cycle moves to DECODE.
  - DECODE(1):
    - Dispatches on opcode to LOAD_MEM, STORE_MEM, JUMP, BRZ, C_EXEC, I_EXEC, or HALT with err 01.
  - LOAD_MEM(2): IorD=1, MEMread=1, mem_req=1. On mem_ready -> LOAD_WB.
  - LOAD_WB(3): Memtoreg=01, regDst=0, regwrite=1 -> FETCH.
  - STORE_MEM(4): IorD=1, MEMwrite=1, mem_req=1. On mem_ready -> FETCH.
  - JUMP(5): PCsrc=01, PCwrite=1 -> FETCH.
  - BRZ(6): ALUsrcA=10, ALUsrcB=0, ALUop=01 (sub), PCsrc=10, PCwritecond=1 -> FETCH.
  - C_EXEC(7):
    - ALUsrcA=10, ALUsrcB=0, ALUop=10.
    - MOVETO, MOVEFROM, NOP skip straight to C_WB; otherwise -> C_WB.
  - C_WB(8):
    - MOVETO: Memtoreg=11, regDst=1, regwrite=1.
    - MOVEFROM: Memtoreg=10, regDst=0, regwrite=1.
    - NOP: no write.
    - Others: Memtoreg=00, regDst=0, regwrite=1.
    - -> FETCH.
  - I_EXEC(9): ALUsrcA=01, ALUsrcB=0, ALUop=11 -> I_WB.
  - I_WB(10): Memtoreg=00, regDst=0, regwrite=1 -> FETCH.
  - HALT(15): all enables 0, halted=1. Exits only via rst.
- Timeout counter:
  - Counts each memory-state cycle with mem_ready=0.
  - Clears on a state change.
  - On reaching MEM_TIMEOUT with mem_ready still 0: -> HALT, err_code=10.
- mem_ready outside memory states is ignored.
- mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT: the access completes; no trap.
- err_code latches the first trap and holds until rst.
- rst mid-access: the request drops in the same cycle; the FSM returns to FETCH.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined:
  - Adds outputs cyc_cnt (32) and instr_cnt (32), both reset to 0.
  - cyc_cnt increments every non-HALT cycle.
  - instr_cnt increments on each transition into FETCH from a non-FETCH state.
  - Both saturate at all-ones.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit codes above);
  - opcode constants;
  - func one-hot bit indices;
  - ALUop, ALUsrcA, Memtoreg and PCsrc encodings;
  - err_code constants.
- One sub-module, mc_mem_wait: timeout counter.
  - Inputs: in_mem_state, state_change, mem_ready.
  - Output: timeout pulse.

Test Plan:
- ADDI (1100), mem_ready tied 1 -> states 0,1,9,10,0. PCwrite pulses once, regwrite in I_WB; instr_cnt=1 with MC_PERF_CNT_EN.
- LOAD, mem_ready delayed 3 cycles in FETCH and in LOAD_MEM -> IRwrite/PCwrite only on the ready cycle; LOAD_WB has Memtoreg=01, regwrite=1; total 11 cycles.
- STORE, mem_ready never asserted -> after 15 wait cycles: HALT, halted=1, err_code=10, MEMwrite=0. Stays there until rst, then FETCH.
- Opcode 0011 -> DECODE to HALT, err_code=01. A later mem_ready or opcode change has no effect.
- CTYPE with func=000000010 (MOVEFROM) -> C_WB with Memtoreg=10, regDst=0. func=000000011 -> HALT, err 01.
- BRZ with zero=1 and zero=0 -> PCwritecond=1 and PCsrc=10 both times. rst asserted during LOAD_MEM -> all outputs 0 that cycle, then FETCH.
